// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register file write-port arbiter for writeback and multi-cycle results
module regfile_wr_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    output logic                     wb_stall,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_reg,
    input  logic [31:0]              mc_data,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WD,
    output logic                     WE,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C = DEPTH[PW:0];
    localparam logic [3:0]      MAX_W   = MAX_WAIT[3:0];

    // FIFO storage; valid_q tracks occupancy per slot so pend_mask needs no pointer math
    logic [4:0]        reg_q  [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [3:0]        wait_q, wait_d;

    logic empty;
    logic pop;
    logic push;
    logic wb_grant;

    assign empty      = (count_q == '0);
    assign mc_ready   = (count_q < DEPTH_C) && !Reset;
    // Transfers to register 0 are accepted but dropped, so they never occupy a slot
    assign push       = mc_valid && mc_ready && (mc_reg != 5'd0);
    assign fifo_count = count_q;

    // Grant selection and starvation counter next state
    always_comb begin
        pop      = 1'b0;
        wb_grant = 1'b0;
        wb_stall = 1'b0;
        wait_d   = wait_q;
        if (Reset) begin
            wait_d = 4'd0;
        end else if (empty) begin
            wb_grant = wb_valid;
            wait_d   = 4'd0;
        end else if (!wb_valid) begin
            pop    = 1'b1;
            wait_d = 4'd0;
        end else if (wait_q < MAX_W) begin
            wb_grant = 1'b1;
            wait_d   = wait_q + 4'd1;
        end else begin
            pop      = 1'b1;
            wb_stall = 1'b1;
            wait_d   = 4'd0;
        end
    end

    // Drive the register file write port from whichever source won
    always_comb begin
        WE       = 1'b0;
        WriteReg = 5'd0;
        WD       = 32'd0;
        if (pop) begin
            WriteReg = reg_q[rd_ptr_q];
            WD       = data_q[rd_ptr_q];
            WE       = (reg_q[rd_ptr_q] != 5'd0);
        end else if (wb_grant) begin
            WriteReg = wb_reg;
            WD       = wb_data;
            WE       = (wb_reg != 5'd0);
        end
    end

    // Occupancy next state
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pending-write mask: one bit per register targeted by any buffered entry
    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pend_mask[reg_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    // Control state: pointers, occupancy, slot valids, starvation counter
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            wait_q   <= 4'd0;
        end else begin
            count_q <= count_d;
            wait_q  <= wait_d;
            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Payload storage; slots are only meaningful while their valid bit is set
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= mc_reg;
            data_q[wr_ptr_q] <= mc_data;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed vector bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic [4:0]  WriteReg;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_reg     (mc_reg),
        .mc_data    (mc_data),
        .WriteReg   (WriteReg),
        .WD         (WD),
        .WE         (WE),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_st;
        logic        e_rdy;
        logic [31:0] e_pm;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic we, input logic [4:0] wa, input logic [31:0] wdd,
                       input logic st, input logic rdy, input logic [31:0] pm, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wr = wr; v.wd = wd; v.mv = mv; v.mr = mr; v.md = md;
        v.e_we = we; v.e_wa = wa; v.e_wd = wdd; v.e_st = st; v.e_rdy = rdy; v.e_pm = pm; v.e_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        mc_valid = 1'b0; mc_reg = 5'd0; mc_data = 32'd0;

        //   rst wv wr     wd            mv mr     md          we wa     wd            st rdy pm            cnt
        // reset holds everything off even with a wb request
        add(1, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 0, 32'h0,        3'd0);
        // zero-latency writeback
        add(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,      1, 5'd5,  32'hDEADBEEF, 0, 1, 32'h0,        3'd0);
        // push reg 7, no bypass, popped next cycle
        add(0, 0, 5'd0,  32'h0,        1, 5'd7,  32'h11,     0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd7,  32'h11,       0, 1, 32'h80,       3'd1);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        // starvation bound: reg 9 loses three times then forces a win
        add(0, 0, 5'd0,  32'h0,        1, 5'd9,  32'h99,     0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        add(0, 1, 5'd1,  32'h101,      0, 5'd0,  32'h0,      1, 5'd1,  32'h101,      0, 1, 32'h200,      3'd1);
        add(0, 1, 5'd2,  32'h102,      0, 5'd0,  32'h0,      1, 5'd2,  32'h102,      0, 1, 32'h200,      3'd1);
        add(0, 1, 5'd3,  32'h103,      0, 5'd0,  32'h0,      1, 5'd3,  32'h103,      0, 1, 32'h200,      3'd1);
        add(0, 1, 5'd4,  32'h104,      0, 5'd0,  32'h0,      1, 5'd9,  32'h99,       1, 1, 32'h200,      3'd1);
        add(0, 1, 5'd4,  32'h104,      0, 5'd0,  32'h0,      1, 5'd4,  32'h104,      0, 1, 32'h0,        3'd0);
        // register 0 from both sources
        add(0, 1, 5'd0,  32'hAAAA,     1, 5'd0,  32'h55,     0, 5'd0,  32'hAAAA,     0, 1, 32'h0,        3'd0);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        // fill to DEPTH under continuous wb
        add(0, 1, 5'd10, 32'hA0,       1, 5'd11, 32'hB0,     1, 5'd10, 32'hA0,       0, 1, 32'h0,        3'd0);
        add(0, 1, 5'd10, 32'hA1,       1, 5'd12, 32'hB1,     1, 5'd10, 32'hA1,       0, 1, 32'h800,      3'd1);
        add(0, 1, 5'd10, 32'hA2,       1, 5'd13, 32'hB2,     1, 5'd10, 32'hA2,       0, 1, 32'h1800,     3'd2);
        add(0, 1, 5'd10, 32'hA3,       1, 5'd14, 32'hB3,     1, 5'd10, 32'hA3,       0, 1, 32'h3800,     3'd3);
        add(0, 1, 5'd10, 32'hA4,       1, 5'd15, 32'hB4,     1, 5'd11, 32'hB0,       1, 0, 32'h7800,     3'd4);
        add(0, 1, 5'd10, 32'hA4,       1, 5'd15, 32'hB4,     1, 5'd10, 32'hA4,       0, 1, 32'h7000,     3'd3);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd12, 32'hB1,       0, 0, 32'hF000,     3'd4);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd13, 32'hB2,       0, 1, 32'hE000,     3'd3);
        // reset with entries buffered, nothing written afterwards
        add(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 0, 32'h0,        3'd0);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        // duplicate register with simultaneous push and pop
        add(0, 0, 5'd0,  32'h0,        1, 5'd6,  32'h61,     0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);
        add(0, 0, 5'd0,  32'h0,        1, 5'd6,  32'h62,     1, 5'd6,  32'h61,       0, 1, 32'h40,       3'd1);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      1, 5'd6,  32'h62,       0, 1, 32'h40,       3'd1);
        add(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,      0, 5'd0,  32'h0,        0, 1, 32'h0,        3'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            Reset    = vecs[i].rst;
            wb_valid = vecs[i].wv;
            wb_reg   = vecs[i].wr;
            wb_data  = vecs[i].wd;
            mc_valid = vecs[i].mv;
            mc_reg   = vecs[i].mr;
            mc_data  = vecs[i].md;
            #1;
            chk($sformatf("v%0d.WE", i),         {31'd0, WE},         {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d.WriteReg", i),   {27'd0, WriteReg},   {27'd0, vecs[i].e_wa});
            chk($sformatf("v%0d.WD", i),         WD,                  vecs[i].e_wd);
            chk($sformatf("v%0d.wb_stall", i),   {31'd0, wb_stall},   {31'd0, vecs[i].e_st});
            chk($sformatf("v%0d.mc_ready", i),   {31'd0, mc_ready},   {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d.pend_mask", i),  pend_mask,           vecs[i].e_pm);
            chk($sformatf("v%0d.fifo_count", i), {29'd0, fifo_count}, {29'd0, vecs[i].e_cnt});
        end

        // Fill three entries, then assert Reset between clock edges
        @(negedge clk);
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h1;
        mc_valid = 1'b1; mc_reg = 5'd20; mc_data = 32'h20;
        @(negedge clk);
        mc_reg = 5'd21; mc_data = 32'h21;
        @(negedge clk);
        mc_reg = 5'd22; mc_data = 32'h22;
        @(negedge clk);
        wb_valid = 1'b0; mc_valid = 1'b0;
        #1;
        chk("pre_rst.fifo_count", {29'd0, fifo_count}, 32'd3);
        chk("pre_rst.pend_mask",  pend_mask,           32'h0070_0000);
        chk("pre_rst.WriteReg",   {27'd0, WriteReg},   32'd20);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst.fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("async_rst.pend_mask",  pend_mask,           32'd0);
        chk("async_rst.WE",         {31'd0, WE},         32'd0);
        chk("async_rst.mc_ready",   {31'd0, mc_ready},   32'd0);
        @(negedge clk);
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("post_rst%0d.WE", k),         {31'd0, WE},         32'd0);
            chk($sformatf("post_rst%0d.fifo_count", k), {29'd0, fifo_count}, 32'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbiter and sequencer for the register file's single write port. It merges the in-order pipeline writeback stream with results from multi-cycle units (mult/div, late loads). Multi-cycle results are buffered in a small FIFO, and a starvation counter bounds how long they wait. The block drives WriteReg/WD/WE of the register file directly and exports a pending-write mask to the hazard unit.

## Interface
- DEPTH, 4: multi-cycle result FIFO entries; power of two, ≥2.
- MAX_WAIT, 3: cycles a non-empty FIFO head may lose to writeback before it forces a win; range 1..15.

- clk  in  1  clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- wb_valid  in  1  pipeline writeback request.
- wb_reg  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- wb_stall  out  1  writeback not taken this cycle; pipeline holds wb_* stable.
- mc_valid  in  1  multi-cycle result offered.
- mc_ready  out  1  FIFO can accept; transfer when mc_valid && mc_ready at clk edge.
- mc_reg  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result.
- WriteReg  out  5  register file write address.
- WD  out  32  register file write data.
- WE  out  1  register file write enable.
- pend_mask  out  32  bit r = 1 iff a FIFO entry targets register r.
- fifo_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- State:
  - FIFO of {reg[4:0], data[31:0]}: read ptr, write ptr, count.
  - wait_cnt: 4-bit counter.
- Grant (combinational from current state and inputs), evaluated in order:
  - FIFO empty: grant wb if wb_valid; wb_stall = 0.
  - FIFO non-empty, wb_valid = 0: grant FIFO head (pop).
  - FIFO non-empty, wb_valid = 1, wait_cnt < MAX_WAIT: grant wb; wait_cnt increments.
  - FIFO non-empty, wb_valid = 1, wait_cnt == MAX_WAIT: grant FIFO head (pop); wb_stall = 1.
- wait_cnt clears to 0 on every pop and whenever the FIFO is empty.
- Write port:
  - WE = 1 only when a grant exists and the granted register ≠ 0.
  - WriteReg/WD carry the granted source's reg/data.
  - With no grant: WE = 0, WriteReg = 0, WD = 0.
- Register 0:
  - A wb write to reg 0 is consumed (wb_stall = 0) with WE = 0.
  - An mc transfer to reg 0 is accepted but not enqueued (count unchanged).
- mc_ready = (count < DEPTH) && !Reset. There is no pass-through when full, even if a pop occurs the same cycle.
- A push and a pop in the same cycle are both allowed when not full: count unchanged, both pointers advance.
- No bypass: a result pushed this cycle is written at the earliest on the following cycle.
- pend_mask:
  - OR of one-hot(reg) over valid entries; bit 0 is always 0.
  - Updates the cycle after push/pop.
  - Duplicate registers in the FIFO keep the bit set until the last such entry pops.
- WAW/RAW ordering between wb and FIFO entries is the hazard unit's responsibility, using pend_mask. The arbiter never reorders FIFO entries among themselves.

## Timing
- Reset asserted, asynchronously:
  - count = 0, pointers = 0, wait_cnt = 0.
  - pend_mask = 0, fifo_count = 0, mc_ready = 0.
  - WE = 0, WriteReg = 0, WD = 0, wb_stall = 0.
  - The first mc transfer is possible at the first edge after deassertion.
- Reset mid-operation: all buffered results are discarded; no write is issued for them.
- Writeback latency: 0 cycles. A granted wb is written into the register file on the same clk edge.
- FIFO latency: push at edge N; earliest pop/write at edge N+1.
- Worst-case FIFO head wait under continuous wb_valid: MAX_WAIT lost cycles, then a win on cycle MAX_WAIT+1.
- wb_stall is asserted for exactly one cycle per forced win. wb_* must be held stable while wb_stall = 1.

## Test plan
- Reset, then wb_valid = 1, wb_reg = 5, wb_data = 0xDEADBEEF for 1 cycle → WE = 1, WriteReg = 5, WD = 0xDEADBEEF same cycle; wb_stall = 0; pend_mask = 0.
- Push mc reg 7 = 0x11 with wb idle → fifo_count = 1 and pend_mask[7] = 1 next cycle; the following cycle WE = 1, WriteReg = 7, WD = 0x11; pend_mask returns to 0.
- MAX_WAIT = 3, one FIFO entry (reg 9), wb_valid held high with regs 1,2,3,4 → writes to regs 1,2,3, then reg 9 with wb_stall = 1; reg 4 written on the next cycle.
- Push 4 entries with wb continuous and DEPTH = 4 → mc_ready = 0 when fifo_count = 4; a 5th mc_valid is held off; mc_ready returns to 1 the cycle after the first pop.
- wb to reg 0 and mc to reg 0 → WE stays 0; wb_stall = 0; fifo_count unchanged; pend_mask[0] = 0.
- Fill 3 entries, assert Reset mid-cycle → immediately fifo_count = 0, pend_mask = 0, WE = 0; no writes occur for the discarded entries after release.
